// File: rtl/hack_kbd_pkg.sv
// Shared types and constants for the PS/2-to-Hack keyboard receiver.
// Optional shift support is selected in the other files by PS2_KEYBOARD_SHIFT_EN.
package hack_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2State_t;

  localparam logic [15:0] KEY_SPACE     = 16'd32;
  localparam logic [15:0] KEY_DIGIT0    = 16'd48;
  localparam logic [15:0] KEY_UPPER_A   = 16'd65;
  localparam logic [15:0] KEY_LOWER_A   = 16'd97;
  localparam logic [15:0] KEY_NEWLINE   = 16'd128;
  localparam logic [15:0] KEY_BACKSPACE = 16'd129;
  localparam logic [15:0] KEY_LEFT      = 16'd130;
  localparam logic [15:0] KEY_UP        = 16'd131;
  localparam logic [15:0] KEY_RIGHT     = 16'd132;
  localparam logic [15:0] KEY_DOWN      = 16'd133;
  localparam logic [15:0] KEY_ESC       = 16'd140;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scancode_map.sv
// Combinational set-2 scan code to Hack key code lookup, indexed by {ext, scanCode}.
// With PS2_KEYBOARD_SHIFT_EN defined, letters are lower case unless shift is held.
module ps2_scancode_map
  import hack_kbd_pkg::*;
(
  input  logic        ext,
  input  logic [7:0]  scanCode,
`ifdef PS2_KEYBOARD_SHIFT_EN
  input  logic        shift,
`endif
  output logic [15:0] code,
  output logic        hit
);

  logic [5:0]  letter;
  logic [16:0] other;
  logic [15:0] letterBase;

  // Letter table: {valid, offset from 'A'}
  always_comb begin
    letter = 6'd0;
    case ({ext, scanCode})
      9'h01C: letter = {1'b1, 5'd0};
      9'h032: letter = {1'b1, 5'd1};
      9'h021: letter = {1'b1, 5'd2};
      9'h023: letter = {1'b1, 5'd3};
      9'h024: letter = {1'b1, 5'd4};
      9'h02B: letter = {1'b1, 5'd5};
      9'h034: letter = {1'b1, 5'd6};
      9'h033: letter = {1'b1, 5'd7};
      9'h043: letter = {1'b1, 5'd8};
      9'h03B: letter = {1'b1, 5'd9};
      9'h042: letter = {1'b1, 5'd10};
      9'h04B: letter = {1'b1, 5'd11};
      9'h03A: letter = {1'b1, 5'd12};
      9'h031: letter = {1'b1, 5'd13};
      9'h044: letter = {1'b1, 5'd14};
      9'h04D: letter = {1'b1, 5'd15};
      9'h015: letter = {1'b1, 5'd16};
      9'h02D: letter = {1'b1, 5'd17};
      9'h01B: letter = {1'b1, 5'd18};
      9'h02C: letter = {1'b1, 5'd19};
      9'h03C: letter = {1'b1, 5'd20};
      9'h02A: letter = {1'b1, 5'd21};
      9'h01D: letter = {1'b1, 5'd22};
      9'h022: letter = {1'b1, 5'd23};
      9'h035: letter = {1'b1, 5'd24};
      9'h01A: letter = {1'b1, 5'd25};
      default: letter = 6'd0;
    endcase
  end

  // Non-letter table: {valid, code}
  always_comb begin
    other = 17'd0;
    case ({ext, scanCode})
      9'h045: other = {1'b1, KEY_DIGIT0 + 16'd0};
      9'h016: other = {1'b1, KEY_DIGIT0 + 16'd1};
      9'h01E: other = {1'b1, KEY_DIGIT0 + 16'd2};
      9'h026: other = {1'b1, KEY_DIGIT0 + 16'd3};
      9'h025: other = {1'b1, KEY_DIGIT0 + 16'd4};
      9'h02E: other = {1'b1, KEY_DIGIT0 + 16'd5};
      9'h036: other = {1'b1, KEY_DIGIT0 + 16'd6};
      9'h03D: other = {1'b1, KEY_DIGIT0 + 16'd7};
      9'h03E: other = {1'b1, KEY_DIGIT0 + 16'd8};
      9'h046: other = {1'b1, KEY_DIGIT0 + 16'd9};
      9'h029: other = {1'b1, KEY_SPACE};
      9'h05A: other = {1'b1, KEY_NEWLINE};
      9'h066: other = {1'b1, KEY_BACKSPACE};
      9'h076: other = {1'b1, KEY_ESC};
      9'h16B: other = {1'b1, KEY_LEFT};
      9'h175: other = {1'b1, KEY_UP};
      9'h174: other = {1'b1, KEY_RIGHT};
      9'h172: other = {1'b1, KEY_DOWN};
      default: other = 17'd0;
    endcase
  end

  // Merge the two tables into the final code
  always_comb begin
`ifdef PS2_KEYBOARD_SHIFT_EN
    letterBase = shift ? KEY_UPPER_A : KEY_LOWER_A;
`else
    letterBase = KEY_UPPER_A;
`endif
    if (letter[5]) begin
      hit  = 1'b1;
      code = letterBase + {11'd0, letter[4:0]};
    end else begin
      hit  = other[16];
      code = other[15:0];
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver producing the Hack keyboard register value.
// Define PS2_KEYBOARD_SHIFT_EN to track shift keys and emit lower-case letters.
module ps2_keyboard
  import hack_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key,
  output logic        new_key,
  output logic        frame_err
);

  logic [1:0]  clkSync;
  logic [1:0]  dataSync;
  logic        filtClk;
  logic [3:0]  filtCnt;
  logic        filtEdge;
  logic        fallEdge;
  logic        dataBit;
  ps2State_t   state;
  ps2State_t   stateNext;
  logic [2:0]  bitCnt;
  logic [7:0]  shiftReg;
  logic        parBit;
  logic [31:0] toCnt;
  logic        timeoutHit;
  logic        byteDone;
  logic        frameBad;
  logic        extFlag;
  logic        brkFlag;
  logic [15:0] mapCode;
  logic        mapHit;
`ifdef PS2_KEYBOARD_SHIFT_EN
  logic        shiftL;
  logic        shiftR;
`endif

  // Two-flop synchronizers, idle-high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
    end else begin
      clkSync  <= {clkSync[0], ps2_clk};
      dataSync <= {dataSync[0], ps2_data};
    end
  end

  // Glitch filter: level follows only after FILTER_LEN consecutive differing samples
  assign filtEdge = (clkSync[1] != filtClk) && (filtCnt == 4'(FILTER_LEN - 1));
  assign fallEdge = filtEdge && filtClk;
  assign dataBit  = dataSync[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filtClk <= 1'b1;
      filtCnt <= 4'd0;
    end else if (clkSync[1] == filtClk) begin
      filtCnt <= 4'd0;
    end else if (filtEdge) begin
      filtClk <= clkSync[1];
      filtCnt <= 4'd0;
    end else begin
      filtCnt <= filtCnt + 4'd1;
    end
  end

  // Inter-edge watchdog, only armed inside a frame
  assign timeoutHit = (state != IDLE) && !filtEdge && (toCnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      toCnt <= 32'd0;
    end else if ((state == IDLE) || filtEdge) begin
      toCnt <= 32'd0;
    end else begin
      toCnt <= toCnt + 32'd1;
    end
  end

  // Frame FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Frame FSM next-state logic
  always_comb begin
    stateNext = state;
    if (timeoutHit) begin
      stateNext = IDLE;
    end else if (fallEdge) begin
      case (state)
        IDLE:    stateNext = dataBit ? IDLE : DATA;
        DATA:    stateNext = (bitCnt == 3'd7) ? PARITY : DATA;
        PARITY:  stateNext = STOP;
        STOP:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end else begin
      stateNext = state;
    end
  end

  // Frame FSM outputs: accepted byte or discarded frame
  always_comb begin
    byteDone = 1'b0;
    frameBad = timeoutHit;
    if ((state == STOP) && fallEdge) begin
      if (dataBit && oddParityOk(shiftReg, parBit)) begin
        byteDone = 1'b1;
      end else begin
        frameBad = 1'b1;
      end
    end else begin
      byteDone = 1'b0;
    end
  end

  // Serial datapath: LSB-first shift and parity capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bitCnt   <= 3'd0;
      shiftReg <= 8'd0;
      parBit   <= 1'b0;
    end else if (state == IDLE) begin
      bitCnt <= 3'd0;
    end else if (fallEdge) begin
      case (state)
        DATA: begin
          shiftReg <= {dataBit, shiftReg[7:1]};
          bitCnt   <= bitCnt + 3'd1;
        end
        PARITY:  parBit <= dataBit;
        default: bitCnt <= bitCnt;
      endcase
    end else begin
      bitCnt <= bitCnt;
    end
  end

  ps2_scancode_map uMap (
    .ext      (extFlag),
    .scanCode (shiftReg),
`ifdef PS2_KEYBOARD_SHIFT_EN
    .shift    (shiftL | shiftR),
`endif
    .code     (mapCode),
    .hit      (mapHit)
  );

  // Key register, prefix flags and strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key       <= 16'd0;
      new_key   <= 1'b0;
      frame_err <= 1'b0;
      extFlag   <= 1'b0;
      brkFlag   <= 1'b0;
`ifdef PS2_KEYBOARD_SHIFT_EN
      shiftL    <= 1'b0;
      shiftR    <= 1'b0;
`endif
    end else begin
      new_key   <= 1'b0;
      frame_err <= frameBad;
      if (byteDone) begin
        if (shiftReg == PREFIX_EXT) begin
          extFlag <= 1'b1;
        end else if (shiftReg == PREFIX_BRK) begin
          brkFlag <= 1'b1;
        end else begin
          extFlag <= 1'b0;
          brkFlag <= 1'b0;
          // Shift codes only update modifier state, never the key register
`ifdef PS2_KEYBOARD_SHIFT_EN
          if (shiftReg == SC_LSHIFT) begin
            shiftL <= ~brkFlag;
          end else if (shiftReg == SC_RSHIFT) begin
            shiftR <= ~brkFlag;
          end else
`endif
          if (mapHit) begin
            if (brkFlag) begin
              if (mapCode == key) key <= 16'd0;
            end else begin
              key     <= mapCode;
              new_key <= (mapCode != key);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: bit-banged PS/2 frames with hand-computed key values.
module tb_ps2_keyboard;
  import hack_kbd_pkg::*;

  localparam int TO = 200;

  logic        clock = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] key;
  logic        new_key;
  logic        frame_err;

  int vectors = 0;
  int miscompares = 0;
  int nkCount = 0;
  int feCount = 0;
  int nkMark = 0;
  int feMark = 0;

  ps2_keyboard #(.FILTER_LEN(4), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key       (key),
    .new_key   (new_key),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (new_key) nkCount++;
    if (frame_err) feCount++;
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2Bit(input logic b);
    ps2_data = b;
    waitClk(5);
    ps2_clk = 1'b0;
    waitClk(10);
    ps2_clk = 1'b1;
    waitClk(5);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic badPar, input logic stopBit);
    logic par;
    par = (~^b) ^ badPar;
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(b[i]);
    ps2Bit(par);
    ps2Bit(stopBit);
    ps2_data = 1'b1;
    waitClk(10);
  endtask

  task automatic sendByte(input logic [7:0] b);
    sendFrame(b, 1'b0, 1'b1);
  endtask

  task automatic mark();
    nkMark = nkCount;
    feMark = feCount;
  endtask

  task automatic checkFrame(input string tag, input logic [15:0] expKey, input int expNk, input int expFe);
    check({tag, "_key"}, {16'd0, key}, {16'd0, expKey});
    check({tag, "_newkey"}, nkCount - nkMark, expNk);
    check({tag, "_frameerr"}, feCount - feMark, expFe);
  endtask

  initial begin
    logic [7:0] partial;
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    waitClk(3);
    check("rst_key", {16'd0, key}, 32'd0);
    check("rst_newkey", {31'd0, new_key}, 32'd0);
    check("rst_frameerr", {31'd0, frame_err}, 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    waitClk(5);

    mark(); sendByte(8'h1C); checkFrame("make_A", 16'h0041, 1, 0);
    mark(); sendByte(8'h1C); checkFrame("repeat_A", 16'h0041, 0, 0);
    mark(); sendByte(8'hF0); sendByte(8'h32); checkFrame("brk_other", 16'h0041, 0, 0);
    mark(); sendByte(8'hF0); sendByte(8'h1C); checkFrame("brk_A", 16'h0000, 0, 0);
    mark(); sendByte(8'h1C); checkFrame("make_A2", 16'h0041, 1, 0);
    mark(); sendFrame(8'h1C, 1'b1, 1'b1); checkFrame("bad_parity", 16'h0041, 0, 1);
    mark(); sendFrame(8'h1C, 1'b0, 1'b0); checkFrame("bad_stop", 16'h0041, 0, 1);
    mark(); sendByte(8'h16); checkFrame("overwrite_1", 16'h0031, 1, 0);
    mark(); sendByte(8'h45); checkFrame("digit_0", 16'h0030, 1, 0);
    mark(); sendByte(8'h1A); checkFrame("letter_Z", 16'h005A, 1, 0);
    mark(); sendByte(8'h05); checkFrame("unmapped", 16'h005A, 0, 0);
    mark(); sendByte(8'h66); checkFrame("backspace", 16'h0081, 1, 0);
    mark(); sendByte(8'h76); checkFrame("esc", 16'h008C, 1, 0);
    mark(); sendByte(8'hE0); sendByte(8'h75); checkFrame("arrow_up", 16'h0083, 1, 0);
    mark(); sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75); checkFrame("arrow_up_brk", 16'h0000, 0, 0);
    mark(); sendByte(8'h75); checkFrame("ext_cleared", 16'h0000, 0, 0);

    // Stall the clock after four data bits
    mark();
    partial = 8'h29;
    ps2Bit(1'b0);
    for (int i = 0; i < 4; i++) ps2Bit(partial[i]);
    ps2_data = 1'b1;
    waitClk(TO + 10);
    check("timeout_frameerr", feCount - feMark, 32'd1);
    check("timeout_state", 32'(dut.state), 32'(IDLE));
    mark(); sendByte(8'h29); checkFrame("after_timeout", 16'h0020, 1, 0);

    // Reset while bit 5 is on the wire
    partial = 8'h1C;
    ps2Bit(1'b0);
    for (int i = 0; i < 5; i++) ps2Bit(partial[i]);
    ps2_data = partial[5];
    waitClk(5);
    ps2_clk = 1'b0;
    waitClk(4);
    reset = 1'b1;
    #1;
    check("reset_async_key", {16'd0, key}, 32'd0);
    waitClk(3);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    check("reset_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    waitClk(5);
    mark(); sendByte(8'h5A); checkFrame("after_reset", 16'h0080, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning the number of consecutive equal synchronized samples needed before the filtered ps2_clk level changes (range 2..15).
REQ-002 SHALL have parameter TIMEOUT, default 20000, meaning the idle clock cycles allowed between filtered ps2_clk edges inside a frame.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all state is rising-edge triggered.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock from the device, asynchronous to clock.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw PS/2 data from the device, asynchronous to clock.
REQ-007 SHALL have port key, output, 16 bits: Hack keyboard register value (0 = no key), read by memory at 0x6000.
REQ-008 SHALL have port new_key, output, 1 bit: one-cycle pulse when key changes to a non-zero value.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is discarded.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through two-flop synchronizers, then filter ps2_clk per FILTER_LEN; a falling edge is a filtered 1->0 transition.
REQ-011 SHALL run a frame FSM with states IDLE, DATA, PARITY and STOP, sampling data on each filtered falling edge.
REQ-012 In IDLE, data=0 SHALL move the FSM to DATA and data=1 SHALL leave it in IDLE (no error).
REQ-013 DATA SHALL shift 8 bits LSB first using a 3-bit counter, and SHALL move to PARITY after bit 7.
REQ-014 PARITY SHALL check for odd parity over the 8 data bits plus the parity bit, and SHALL always move to STOP.
REQ-015 STOP SHALL return to IDLE; a byte is accepted only if parity is good and stop=1, otherwise frame_err SHALL pulse and the byte SHALL be dropped.
REQ-016 In any state other than IDLE, TIMEOUT cycles without a filtered edge SHALL force IDLE and pulse frame_err; the counter SHALL clear on every filtered edge.
REQ-017 Accepted byte 0xE0 SHALL set the ext flag and 0xF0 SHALL set the brk flag; both flags SHALL clear after the next non-prefix byte.
REQ-018 A make code SHALL be looked up as {ext, byte}: letters map to 65..90, digits to 48..57, space to 32, Enter to 128, Backspace to 129, E0 6B/75/74/72 to 130/131/132/133, and Esc to 140; unmapped codes SHALL be ignored.
REQ-019 A mapped make SHALL set key to the code on the cycle after the STOP sample (latency 1 cycle).
REQ-020 new_key SHALL pulse on that same cycle only if the code differs from the current key, so typematic repeats produce no pulse.
REQ-021 A make code arriving while another key is held SHALL overwrite key.
REQ-022 A break SHALL clear key to 0 only if its mapped code equals the current key; otherwise key SHALL be unchanged.
REQ-023 The ps2_clk/ps2_data inputs SHALL be receive-only; there is no host-to-device path.

Reset
REQ-024 Reset SHALL asynchronously force key=0, new_key=0, frame_err=0, FSM=IDLE, ext=brk=0, timeout counter=0, filtered clock=1 and synchronizers=1.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte; after release, the next start bit SHALL begin a fresh frame.

Configuration
REQ-026 With PS2_KEYBOARD_SHIFT_EN defined, the block SHALL track left shift (0x12) and right shift (0x59) make/break and map letters to 97..122 unless a shift is held (then 65..90); shift codes SHALL never change key.
REQ-027 Without PS2_KEYBOARD_SHIFT_EN, no shift state SHALL exist and letters SHALL always map to 65..90.

Structure
REQ-028 Package hack_kbd_pkg SHALL hold the FSM state enum, the Hack key constants (KEY_NEWLINE=128, KEY_BACKSPACE=129, arrows 130..133, KEY_ESC=140) and the prefix constants 0xE0 and 0xF0.
REQ-029 The scan-code lookup SHALL be a combinational sub-module ps2_scancode_map with inputs {ext, byte[7:0]} (plus shift under the macro) and outputs code[15:0] and hit.

Verification
REQ-030 Frame 0x1C with good parity -> key=0x0041 and new_key pulses once; resend 0x1C -> no pulse and key stays 0x0041.
REQ-031 Bytes F0, 1C after 'A' -> key=0x0000; bytes F0, 32 while 'A' is held -> key stays 0x0041.
REQ-032 Frame 0x1C with bad parity, or with stop=0 -> frame_err pulses once and key is unchanged.
REQ-033 Bytes E0, 75 -> key=131 (0x0083); then E0, F0, 75 -> key=0.
REQ-034 Stop ps2_clk after 4 data bits for TIMEOUT+10 cycles -> frame_err pulses and FSM=IDLE; the next 0x29 frame -> key=32.
REQ-035 Assert reset during bit 5 of a frame -> key=0 immediately; after release, frame 0x5A -> key=128.
